// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared 2-bit counter encodings and saturating update for the tournament predictor
package bp_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [1:0] PHT_RESET     = CNT_WT;
  // Chooser starts weakly on the local side.
  localparam logic [1:0] CHOOSER_RESET = CNT_WNT;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end else begin
      return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    end
  endfunction

endpackage

// File: rtl/bp_sat_table.sv
// rtl/bp_sat_table.sv - 2^N x 2-bit saturating counter table, one read port and one read-modify-write port
module bp_sat_table
  import bp_pkg::*;
#(
  parameter int         N         = 8,
  parameter logic [1:0] RESET_VAL = PHT_RESET
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] rd_idx_i,
  output logic [1:0]   rd_cnt_o,
  input  logic [N-1:0] upd_idx_i,
  input  logic         upd_en_i,
  input  logic         upd_dir_i,
  output logic [1:0]   upd_cnt_o
);

  logic [1:0] cnt_q [2**N];

  assign rd_cnt_o  = cnt_q[rd_idx_i];
  assign upd_cnt_o = cnt_q[upd_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2**N; i++) begin
        cnt_q[i] <= RESET_VAL;
      end
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= sat_next(cnt_q[upd_idx_i], upd_dir_i);
    end
  end

endmodule

// File: rtl/branch_predict_tournament.sv
// rtl/branch_predict_tournament.sv - local/gshare tournament predictor with chooser, Decode register and stats
module branch_predict_tournament
  import bp_pkg::*;
#(
  parameter int LHT_DEPTH     = 10,
  parameter int LHIST_W       = 6,
  parameter int GHR_W         = 8,
  parameter int CHOOSER_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcF,
  input  logic        branchD,
  input  logic [31:0] pcM,
  input  logic        branchM,
  input  logic        actual_takeM,
  input  logic        pred_wrongM,
  output logic        pred_takeF,
  output logic        pred_takeD,
  output logic        pred_srcD,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  logic [LHIST_W-1:0] lht_q [2**LHT_DEPTH];
  logic [GHR_W-1:0]   ghr_q, ghr_d;
  logic               pred_q, src_q;
  logic [31:0]        branch_cnt_q, mispred_cnt_q;

  logic [LHT_DEPTH-1:0]     lidx_f, lidx_m;
  logic [LHIST_W-1:0]       lh_f, lh_m, lpidx_f, lpidx_m;
  logic [GHR_W-1:0]         gidx_f, gidx_m;
  logic [CHOOSER_DEPTH-1:0] cidx_f, cidx_m;
  logic [1:0]               l_cnt_f, l_cnt_m, g_cnt_f, g_cnt_m, c_cnt_f, c_cnt_m;
  logic                     l_pred_m, g_pred_m;
  logic                     unused_bits;

  assign lidx_f  = pcF[LHT_DEPTH+1:2];
  assign lh_f    = lht_q[lidx_f];
  assign lpidx_f = lh_f ^ pcF[LHIST_W+1:2];
  assign gidx_f  = ghr_q ^ pcF[GHR_W+1:2];
  assign cidx_f  = pcF[CHOOSER_DEPTH+1:2];

  assign lidx_m  = pcM[LHT_DEPTH+1:2];
  assign lh_m    = lht_q[lidx_m];
  assign lpidx_m = lh_m ^ pcM[LHIST_W+1:2];
  assign gidx_m  = ghr_q ^ pcM[GHR_W+1:2];
  assign cidx_m  = pcM[CHOOSER_DEPTH+1:2];

  assign l_pred_m = l_cnt_m[1];
  assign g_pred_m = g_cnt_m[1];

  bp_sat_table #(.N(LHIST_W), .RESET_VAL(PHT_RESET)) u_local_pht (
    .clk_i(clk), .rst_i(rst),
    .rd_idx_i(lpidx_f), .rd_cnt_o(l_cnt_f),
    .upd_idx_i(lpidx_m), .upd_en_i(branchM), .upd_dir_i(actual_takeM), .upd_cnt_o(l_cnt_m)
  );

  bp_sat_table #(.N(GHR_W), .RESET_VAL(PHT_RESET)) u_global_pht (
    .clk_i(clk), .rst_i(rst),
    .rd_idx_i(gidx_f), .rd_cnt_o(g_cnt_f),
    .upd_idx_i(gidx_m), .upd_en_i(branchM), .upd_dir_i(actual_takeM), .upd_cnt_o(g_cnt_m)
  );

  // The chooser only learns when the two components disagree; counting up favours global.
  bp_sat_table #(.N(CHOOSER_DEPTH), .RESET_VAL(CHOOSER_RESET)) u_chooser (
    .clk_i(clk), .rst_i(rst),
    .rd_idx_i(cidx_f), .rd_cnt_o(c_cnt_f),
    .upd_idx_i(cidx_m), .upd_en_i(branchM & (l_pred_m != g_pred_m)),
    .upd_dir_i(g_pred_m == actual_takeM), .upd_cnt_o(c_cnt_m)
  );

  assign pred_takeF = c_cnt_f[1] ? g_cnt_f[1] : l_cnt_f[1];

  always_comb begin
    ghr_d = ghr_q;
    if (branchM) begin
      ghr_d = {ghr_q[GHR_W-2:0], actual_takeM};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**LHT_DEPTH; i++) begin
        lht_q[i] <= '0;
      end
      ghr_q <= '0;
    end else begin
      if (branchM) begin
        lht_q[lidx_m] <= {lh_m[LHIST_W-2:0], actual_takeM};
      end
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      pred_q <= 1'b0;
      src_q  <= 1'b0;
    end else if (!stallD) begin
      pred_q <= pred_takeF;
      src_q  <= c_cnt_f[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (branchM) begin
      branch_cnt_q  <= branch_cnt_q + 32'd1;
      mispred_cnt_q <= mispred_cnt_q + {31'd0, pred_wrongM};
    end
  end

  assign pred_takeD  = branchD & pred_q;
  assign pred_srcD   = src_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  assign unused_bits = ^{pcF, pcM, c_cnt_m};

endmodule

// File: tb/tb_branch_predict_tournament.sv
// tb/tb_branch_predict_tournament.sv - directed self-checking bench for branch_predict_tournament
module tb_branch_predict_tournament;

  logic        clk = 1'b0;
  logic        rst, stallD, flushD, branchD, branchM, actual_takeM, pred_wrongM;
  logic [31:0] pcF, pcM;
  logic        pred_takeF, pred_takeD, pred_srcD;
  logic [31:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  branch_predict_tournament dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD),
    .pcF(pcF), .branchD(branchD), .pcM(pcM), .branchM(branchM),
    .actual_takeM(actual_takeM), .pred_wrongM(pred_wrongM),
    .pred_takeF(pred_takeF), .pred_takeD(pred_takeD), .pred_srcD(pred_srcD),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stallD = 1'b0; flushD = 1'b0; branchD = 1'b0; branchM = 1'b0;
    actual_takeM = 1'b0; pred_wrongM = 1'b0; pcF = 32'h0; pcM = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state: every path weakly taken, chooser on local
    pcF = 32'h100;
    #1;
    check("reset_predF", {31'd0, pred_takeF}, 32'd1);
    check("reset_predD_nobranch", {31'd0, pred_takeD}, 32'd0);
    tick();
    branchD = 1'b1;
    #1;
    check("capture_predD", {31'd0, pred_takeD}, 32'd1);
    check("capture_srcD", {31'd0, pred_srcD}, 32'd0);
    check("reset_branch_cnt", branch_cnt, 32'd0);
    check("reset_mispred_cnt", mispred_cnt, 32'd0);

    // Two not-taken commits at 0x100 walk local PHT[0] WT->WNT->SNT
    pcM = 32'h100; actual_takeM = 1'b0; branchM = 1'b1;
    tick();
    check("nt1_predF", {31'd0, pred_takeF}, 32'd0);
    tick();
    branchM = 1'b0;
    #1;
    check("nt2_predF", {31'd0, pred_takeF}, 32'd0);
    check("nt2_branch_cnt", branch_cnt, 32'd2);
    check("nt2_predD", {31'd0, pred_takeD}, 32'd0);

    // Alternating pattern: local learns it, chooser ends on local
    do_reset();
    pcM = 32'h200;
    branchM = 1'b1;
    for (int i = 0; i < 40; i++) begin
      actual_takeM = (i % 2 == 0);
      tick();
    end
    branchM = 1'b0;
    pcF = 32'h200;
    #1;
    check("alt_predF_T", {31'd0, pred_takeF}, 32'd1);
    check("alt_branch_cnt", branch_cnt, 32'd40);
    tick();
    check("alt_predD", {31'd0, pred_takeD}, 32'd1);
    check("alt_srcD_local", {31'd0, pred_srcD}, 32'd0);
    branchM = 1'b1; actual_takeM = 1'b1;
    tick();
    branchM = 1'b0;
    #1;
    check("alt_predF_N", {31'd0, pred_takeF}, 32'd0);

    // Stall holds a taken Decode prediction, flush beats stall
    check("stall_pre_predD", {31'd0, pred_takeD}, 32'd1);
    stallD = 1'b1;
    pcF = 32'h54;
    #1;
    check("stall_predF", {31'd0, pred_takeF}, 32'd0);
    tick();
    check("stall_hold_predD", {31'd0, pred_takeD}, 32'd1);
    flushD = 1'b1;
    tick();
    flushD = 1'b0; stallD = 1'b0;
    #1;
    check("flush_predD", {31'd0, pred_takeD}, 32'd0);

    // Same-cycle Fetch read and Memory write of one entry
    do_reset();
    pcF = 32'h300; pcM = 32'h300; actual_takeM = 1'b0; branchM = 1'b1;
    #1;
    check("rw_old_predF", {31'd0, pred_takeF}, 32'd1);
    tick();
    branchM = 1'b0;
    #1;
    check("rw_new_predF", {31'd0, pred_takeF}, 32'd0);

    // Stats counters, then reset in the middle of training
    do_reset();
    pcF = 32'h100; pcM = 32'h100; actual_takeM = 1'b0;
    branchM = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pred_wrongM = (i == 1 || i == 3);
      tick();
    end
    branchM = 1'b0; pred_wrongM = 1'b0;
    #1;
    check("stat_branch_cnt", branch_cnt, 32'd5);
    check("stat_mispred_cnt", mispred_cnt, 32'd2);
    check("stat_predF_trained", {31'd0, pred_takeF}, 32'd0);
    tick();
    check("stat_hold_branch_cnt", branch_cnt, 32'd5);
    rst = 1'b1; branchM = 1'b1; pred_wrongM = 1'b1;
    tick();
    rst = 1'b0; branchM = 1'b0; pred_wrongM = 1'b0;
    #1;
    check("rst_branch_cnt", branch_cnt, 32'd0);
    check("rst_mispred_cnt", mispred_cnt, 32'd0);
    check("rst_predF_table", {31'd0, pred_takeF}, 32'd1);
    check("rst_predD", {31'd0, pred_takeD}, 32'd0);
    check("rst_srcD", {31'd0, pred_srcD}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
